key_schedule_seq: RTL and testbench
===================================

Name: key_schedule_seq

Overview:
- Sequential AES-128 key schedule engine; sits directly downstream of the combinational one-round key expander.
- Accepts a 128-bit cipher key over a valid/ready handshake and runs one expansion round per clock for 10 cycles.
- Stores all 11 round keys and serves them to the round datapath through a registered indexed read port.

Parameters:
- NR, 10, number of rounds; fixed for AES-128; slots 0..NR stored.
- IDX_W, 4, round-key index width; must satisfy 2**IDX_W > NR.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- key_in  input  128  cipher key; w0 = bits [127:96], w3 = bits [31:0]
- key_valid  input  1  key_in valid
- key_ready  output  1  block can accept a key
- busy  output  1  expansion in progress
- done  output  1  all NR+1 round keys valid
- rk_rd_en  input  1  read request
- rk_idx  input  IDX_W  round-key index, 0..NR
- rk_out  output  128  round key, registered
- rk_valid  output  1  one-cycle pulse, rk_out updated

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; busy=0; done=0; key_ready=0 during reset, 1 from the first edge after release.
  - rk_out=0; rk_valid=0; all slots=0; round counter=0; rcon=8'h01.
- States: IDLE, EXPAND, DONE.
- key_ready=1 in IDLE and DONE; 0 in EXPAND, so a key_valid during EXPAND is stalled, not dropped.
- Load handshake (key_valid & key_ready at edge T0):
  - slot0 <= key_in; working words <= key_in; round <= 1; rcon <= 01.
  - state <= EXPAND; busy <= 1; done <= 0.
- EXPAND, each edge:
  - next = key_round_step(working, rcon); slot[round] <= next; working <= next.
  - rcon <= xtime(rcon), giving the sequence 01,02,04,08,10,20,40,80,1B,36.
  - round <= round+1.
  - On the edge writing slot NR (T10): state <= DONE, busy <= 0, done <= 1.
- Latency: done high 10 cycles after the accepting edge. No early-out and no pause.
- Read:
  - A read is legal when rk_rd_en=1, done=1 and rk_idx <= NR.
  - Legal read: next edge rk_out <= slot[rk_idx] and rk_valid <= 1.
  - Illegal read (not done, or idx > NR): ignored; rk_out holds; rk_valid=0.
- Simultaneous legal read and new key load in DONE:
  - Read-before-write; read returns the old slot contents.
  - done drops on the same edge.
- Re-key from DONE overwrites all slots progressively. Old keys are unreadable once done=0.
- Reset mid-EXPAND: immediate return to reset values; the partial schedule is discarded.
- All arithmetic is GF(2^8) or XOR; the round counter saturates at NR and never wraps.

Optional Feature:
- Macro: KEY_SCHED_ZEROIZE_EN.
- Defined:
  - Adds input port zeroize (1 bit).
  - On an edge with zeroize=1: all slots, working words and rk_out are cleared to 0.
  - Also: state <= IDLE, done <= 0, busy <= 0, rk_valid <= 0.
  - zeroize has priority over load, expansion and read.
- Undefined: port absent; slots retain contents until overwritten or rst.

Decomposition:
- Package aes_pkg:
  - NR, NK=4, word typedef (32-bit), round-key typedef (128-bit).
  - State enum {IDLE, EXPAND, DONE}, xtime function, RCON_INIT=8'h01.
- Sub-module key_round_step: combinational single round.
  - RotWord, SubWord via the existing S-box, rcon XOR into the MSB byte, chained XOR w0..w3.
  - Takes rcon as an 8-bit input, not an iteration count.
- Top level holds the FSM, counter, rcon register, slot array and read port.

Test Plan:
- FIPS-197 load:
  - Stimulus: key 2b7e1516_28aed2a6_abf71588_09cf4f3c, then read idx 1 and idx 10.
  - Required: done exactly 10 cycles after handshake; idx1 = a0fafe17_88542cb1_23a33939_2a6c7605; idx10 = d014f9a8_c9ee2589_e13f0cc8_b6630ca6.
- rcon wrap:
  - Stimulus: all-zero key; read idx 9 and idx 10.
  - Required: idx 9 and idx 10 match the FIPS reference values, which exercise rcon 1B and 36.
- Back-pressure:
  - Stimulus: key_valid held during EXPAND.
  - Required: key_ready=0 for 10 cycles; second key accepted on the first DONE cycle; done deasserts the next cycle.
- Illegal reads:
  - Stimulus: read idx 3 while busy; read idx 11 and idx 15 in DONE.
  - Required: rk_valid stays 0; rk_out unchanged.
- Reset mid-expansion:
  - Stimulus: assert rst at cycle 5 of EXPAND.
  - Required: busy=0, done=0, rk_out=0 asynchronously; a fresh load completes correctly.
- Read/load collision:
  - Stimulus: in DONE, read idx 0 on the same edge a new key is accepted.
  - Required: rk_out = old key; later slot0 = new key.
  - With KEY_SCHED_ZEROIZE_EN defined: a zeroize pulse in DONE clears the slots, and a subsequent read of idx 0 is rejected.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the key schedule slice: sizes, word types,
// FSM state encoding and the GF(2^8) helpers used by the round step.
package aes_pkg;

    localparam int NR = 10;
    localparam int NK = 4;

    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] rkey_t;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // a^254 is the multiplicative inverse; it also maps 0 to 0 as the S-box needs
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int unsigned i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    // AES S-box: field inverse followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/key_round_step.sv
// Combinational single round of the AES-128 key expansion.
// Produces the next four words from the current four and the round constant.
module key_round_step
    import aes_pkg::*;
(
    input  logic [127:0] key_in,
    input  logic [7:0]   rcon,
    output logic [127:0] key_out
);

    word_t w0, w1, w2, w3;
    word_t rot, sub;
    word_t n0, n1, n2, n3;

    // RotWord, SubWord, rcon into the top byte, then the chained XOR
    always_comb begin
        w0  = key_in[127:96];
        w1  = key_in[95:64];
        w2  = key_in[63:32];
        w3  = key_in[31:0];
        rot = {w3[23:0], w3[31:24]};
        sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        n0  = w0 ^ sub ^ {rcon, 24'h000000};
        n1  = w1 ^ n0;
        n2  = w2 ^ n1;
        n3  = w3 ^ n2;
        key_out = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/key_schedule_seq.sv
// Sequential AES-128 key schedule: accepts a cipher key, expands one round
// per clock, stores all NR+1 round keys and serves them through a registered
// indexed read port.
// Optional: define KEY_SCHED_ZEROIZE_EN to add a zeroize input that clears
// all key material and returns the engine to IDLE.
module key_schedule_seq
    import aes_pkg::*;
#(
    parameter int NR    = aes_pkg::NR,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [127:0]     key_in,
    input  logic             key_valid,
    output logic             key_ready,
    output logic             busy,
    output logic             done,
    input  logic             rk_rd_en,
    input  logic [IDX_W-1:0] rk_idx,
    output logic [127:0]     rk_out,
    output logic             rk_valid
`ifdef KEY_SCHED_ZEROIZE_EN
    ,
    input  logic             zeroize
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    state_t           state, state_next;
    logic [127:0]     slots [0:NR];
    logic [127:0]     working;
    logic [127:0]     next_key;
    logic [IDX_W-1:0] round;
    logic [7:0]       rcon;
    logic             load;
    logic             rd_ok;
    logic             clear;

    key_round_step u_step (
        .key_in  (working),
        .rcon    (rcon),
        .key_out (next_key)
    );

    // Zeroize request, tied off when the feature is not built
    always_comb begin
`ifdef KEY_SCHED_ZEROIZE_EN
        clear = zeroize;
`else
        clear = 1'b0;
`endif
    end

    // Next-state, load handshake and read legality
    always_comb begin
        state_next = state;
        load       = key_valid & key_ready & ~clear;
        rd_ok      = rk_rd_en & done & (rk_idx <= LAST_IDX) & ~clear;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (load) state_next = EXPAND;
                EXPAND:  if (round == LAST_IDX) state_next = DONE;
                DONE:    if (load) state_next = EXPAND;
                default: state_next = IDLE;
            endcase
        end
    end

    // State register and the registered status flags derived from it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            key_ready <= 1'b0;
        end else begin
            state     <= state_next;
            busy      <= (state_next == EXPAND);
            done      <= (state_next == DONE);
            key_ready <= (state_next != EXPAND);
        end
    end

    // Key storage, expansion datapath and read port; the read samples the
    // slot before a same-edge load overwrites it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i <= NR; i++) slots[i] <= '0;
            working  <= '0;
            round    <= '0;
            rcon     <= RCON_INIT;
            rk_out   <= '0;
            rk_valid <= 1'b0;
        end else if (clear) begin
            for (int unsigned i = 0; i <= NR; i++) slots[i] <= '0;
            working  <= '0;
            round    <= '0;
            rcon     <= RCON_INIT;
            rk_out   <= '0;
            rk_valid <= 1'b0;
        end else begin
            rk_valid <= rd_ok;
            if (rd_ok) rk_out <= slots[rk_idx];
            if (load) begin
                slots[0] <= key_in;
                working  <= key_in;
                round    <= ONE_IDX;
                rcon     <= RCON_INIT;
            end else if (state == EXPAND) begin
                slots[round] <= next_key;
                working      <= next_key;
                rcon         <= xtime(rcon);
                if (round != LAST_IDX) round <= round + ONE_IDX;
            end
        end
    end

endmodule

// File: tb/tb_key_schedule_seq.sv
// Self-checking bench for key_schedule_seq: FIPS-197 vector table, random
// keys against a word-level key expansion model, and hand-written sequences
// for back-pressure, illegal reads, reset, read/load collision and zeroize.
module tb_key_schedule_seq;

    logic         clk;
    logic         rst;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         done;
    logic         rk_rd_en;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic         rk_valid;
`ifdef KEY_SCHED_ZEROIZE_EN
    logic         zeroize;
`endif

    key_schedule_seq #(.NR(10), .IDX_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .busy      (busy),
        .done      (done),
        .rk_rd_en  (rk_rd_en),
        .rk_idx    (rk_idx),
        .rk_out    (rk_out),
        .rk_valid  (rk_valid)
`ifdef KEY_SCHED_ZEROIZE_EN
        ,
        .zeroize   (zeroize)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    logic [7:0]   sb [0:255];
    logic [7:0]   rcon_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                     8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [127:0] mdl_rk [0:10];

    function automatic logic [7:0] pmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] s;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (pmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                     ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            sb[x] = s;
        end
    endtask

    task automatic compute_model(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t = t ^ {rcon_tab[i / 4 - 1], 24'h000000};
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            mdl_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a key, wait (bounded) for key_ready, complete the handshake
    task automatic start_load(input logic [127:0] key);
        int n;
        key_in    = key;
        key_valid = 1'b1;
        n = 0;
        while (!key_ready && n < 30) begin
            tick();
            n++;
        end
        if (!key_ready) chk("load_ready_timeout", 128'(key_ready), 128'd1);
        tick();
        key_valid = 1'b0;
    endtask

    // Edges from the accepting edge until done is seen (bounded)
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    task automatic read_rk(input logic [3:0] idx, output logic v, output logic [127:0] d);
        rk_idx   = idx;
        rk_rd_en = 1'b1;
        tick();
        rk_rd_en = 1'b0;
        v = rk_valid;
        d = rk_out;
    endtask

    typedef struct {
        logic [127:0] key;
        logic [3:0]   idx;
        logic [127:0] exp;
    } vec_t;

    vec_t         vt [0:5];
    logic [127:0] exp_rk_out;
    logic [127:0] ka, kb, d;
    logic [3:0]   ridx;
    logic         v;
    int           lat, lowcnt;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        key_in    = '0;
        key_valid = 1'b0;
        rk_rd_en  = 1'b0;
        rk_idx    = '0;
`ifdef KEY_SCHED_ZEROIZE_EN
        zeroize   = 1'b0;
`endif
        build_sbox();

        vt[0] = '{128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 4'd0,
                  128'h2b7e1516_28aed2a6_abf71588_09cf4f3c};
        vt[1] = '{128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 4'd1,
                  128'ha0fafe17_88542cb1_23a33939_2a6c7605};
        vt[2] = '{128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 4'd10,
                  128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6};
        vt[3] = '{128'h0, 4'd2, 128'h9b9898c9_f9fbfbaa_9b9898c9_f9fbfbaa};
        vt[4] = '{128'h0, 4'd9, 128'hb1d4d8e2_8a7db9da_1d7bb3de_4c664941};
        vt[5] = '{128'h0, 4'd10, 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e};

        // Reset values
        repeat (2) tick();
        chk("rst_key_ready", 128'(key_ready), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_rk_out", rk_out, 128'd0);
        chk("rst_rk_valid", 128'(rk_valid), 128'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_key_ready", 128'(key_ready), 128'd1);
        exp_rk_out = '0;

        // Known-answer table
        for (int i = 0; i < 6; i++) begin
            start_load(vt[i].key);
            wait_done(lat);
            chk("kat_latency", 128'(lat), 128'd10);
            read_rk(vt[i].idx, v, d);
            chk("kat_valid", 128'(v), 128'd1);
            chk("kat_rk", d, vt[i].exp);
            exp_rk_out = vt[i].exp;
        end

        // Random keys against the model, random legal and illegal indices
        for (int n = 0; n < 8; n++) begin
            ka = {$urandom, $urandom, $urandom, $urandom};
            compute_model(ka);
            start_load(ka);
            wait_done(lat);
            chk("rnd_latency", 128'(lat), 128'd10);
            for (int r = 0; r < 3; r++) begin
                ridx = 4'($urandom_range(0, 15));
                read_rk(ridx, v, d);
                if (ridx <= 4'd10) begin
                    chk("rnd_valid", 128'(v), 128'd1);
                    chk("rnd_rk", d, mdl_rk[ridx]);
                    exp_rk_out = mdl_rk[ridx];
                end else begin
                    chk("rnd_illegal_valid", 128'(v), 128'd0);
                    chk("rnd_illegal_hold", d, exp_rk_out);
                end
            end
        end

        // Back-pressure: key_valid held through expansion
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom};
        start_load(ka);
        key_in    = kb;
        key_valid = 1'b1;
        lowcnt = 0;
        while (!key_ready && lowcnt < 30) begin
            lowcnt++;
            tick();
        end
        chk("bp_ready_low_cycles", 128'(lowcnt), 128'd10);
        chk("bp_done_at_ready", 128'(done), 128'd1);
        tick();
        key_valid = 1'b0;
        chk("bp_done_drops", 128'(done), 128'd0);
        chk("bp_busy_again", 128'(busy), 128'd1);
        wait_done(lat);
        chk("bp_latency", 128'(lat), 128'd10);
        compute_model(kb);
        read_rk(4'd0, v, d);
        chk("bp_slot0", d, kb);
        read_rk(4'd10, v, d);
        chk("bp_slot10", d, mdl_rk[10]);
        exp_rk_out = mdl_rk[10];

        // Illegal reads: while busy, and out-of-range indices in DONE
        ka = {$urandom, $urandom, $urandom, $urandom};
        start_load(ka);
        repeat (2) tick();
        read_rk(4'd3, v, d);
        chk("busy_read_valid", 128'(v), 128'd0);
        chk("busy_read_hold", d, exp_rk_out);
        wait_done(lat);
        read_rk(4'd11, v, d);
        chk("idx11_valid", 128'(v), 128'd0);
        chk("idx11_hold", d, exp_rk_out);
        read_rk(4'd15, v, d);
        chk("idx15_valid", 128'(v), 128'd0);
        chk("idx15_hold", d, exp_rk_out);

        // Reset in the middle of expansion
        start_load(ka);
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        chk("amid_rst_busy", 128'(busy), 128'd0);
        chk("amid_rst_done", 128'(done), 128'd0);
        chk("amid_rst_rk_out", rk_out, 128'd0);
        chk("amid_rst_key_ready", 128'(key_ready), 128'd0);
        tick();
        rst = 1'b0;
        exp_rk_out = '0;
        tick();
        read_rk(4'd0, v, d);
        chk("post_rst_read_rejected", 128'(v), 128'd0);
        kb = {$urandom, $urandom, $urandom, $urandom};
        compute_model(kb);
        start_load(kb);
        wait_done(lat);
        chk("fresh_latency", 128'(lat), 128'd10);
        read_rk(4'd5, v, d);
        chk("fresh_slot5", d, mdl_rk[5]);

        // Read/load collision in DONE: read sees the old key
        ka = {$urandom, $urandom, $urandom, $urandom};
        key_in    = ka;
        key_valid = 1'b1;
        rk_idx    = 4'd0;
        rk_rd_en  = 1'b1;
        tick();
        key_valid = 1'b0;
        rk_rd_en  = 1'b0;
        chk("coll_valid", 128'(rk_valid), 128'd1);
        chk("coll_old_key", rk_out, kb);
        chk("coll_done_drop", 128'(done), 128'd0);
        chk("coll_busy", 128'(busy), 128'd1);
        wait_done(lat);
        chk("coll_latency", 128'(lat), 128'd10);
        read_rk(4'd0, v, d);
        chk("coll_new_slot0", d, ka);

`ifdef KEY_SCHED_ZEROIZE_EN
        // Zeroize in DONE clears everything and blocks reads
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        chk("zero_done", 128'(done), 128'd0);
        chk("zero_busy", 128'(busy), 128'd0);
        chk("zero_rk_out", rk_out, 128'd0);
        read_rk(4'd0, v, d);
        chk("zero_read_rejected", 128'(v), 128'd0);
        chk("zero_read_hold", d, 128'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
